// File: rtl/data_memory_sized.sv
// Byte-addressed 32-bit data memory with byte/half/word access, a fixed
// access latency and one-cycle done pulse. Load data is on "rdata" since "do" is a reserved word.
module data_memory_sized #(
    parameter int ADDR_W  = 5,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] a,
    input  logic [31:0] di,
    output logic        ready,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state, state_nx;
    logic [3:0]          cnt;
    logic                we_q, sext_q;
    logic [1:0]          size_q;
    logic [ADDR_W+1:0]   a_q;
    logic [31:0]         di_q;
    logic                accept, exec, misalign;
    logic [3:0]          wmask;
    logic [31:0]         wdata, word_rd, byte_sh, half_sh, load_val;
    logic                unused_a_hi;

    logic [31:0] mem [DEPTH] = '{default: '0};

    // Address bits above the word index wrap the array and are dropped.
    assign unused_a_hi = ^a[31:ADDR_W+2];

    assign accept = (state == IDLE) && req;
    assign exec   = (state == ACCESS) && (cnt == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req) state_nx = ACCESS;
            ACCESS:  if (cnt == 4'd0) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == IDLE);
    end

    assign misalign = (size_q == 2'b11) ||
                      (size_q == 2'b01 && a_q[0]) ||
                      (size_q == 2'b10 && a_q[1:0] != 2'b00);

    // Store data is replicated across lanes so the mask alone picks the target lanes.
    always_comb begin
        wmask = 4'b1111;
        wdata = di_q;
        case (size_q)
            2'b00: begin
                wmask = 4'b0001 << a_q[1:0];
                wdata = {4{di_q[7:0]}};
            end
            2'b01: begin
                wmask = a_q[1] ? 4'b1100 : 4'b0011;
                wdata = {2{di_q[15:0]}};
            end
            default: ;
        endcase
    end

    assign word_rd = mem[a_q[ADDR_W+1:2]];
    assign byte_sh = word_rd >> {a_q[1:0], 3'b000};
    assign half_sh = word_rd >> {a_q[1], 4'b0000};

    always_comb begin
        load_val = word_rd;
        case (size_q)
            2'b00:   load_val = {{24{sext_q & byte_sh[7]}}, byte_sh[7:0]};
            2'b01:   load_val = {{16{sext_q & half_sh[15]}}, half_sh[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= 4'd0;
            done   <= 1'b0;
            err    <= 1'b0;
            rdata  <= 32'd0;
            we_q   <= 1'b0;
            sext_q <= 1'b0;
            size_q <= 2'b00;
            a_q    <= '0;
            di_q   <= 32'd0;
        end else begin
            done <= exec;
            if (accept) begin
                cnt    <= 4'(LATENCY - 1);
                we_q   <= we;
                sext_q <= sign_ext;
                size_q <= size;
                a_q    <= a[ADDR_W+1:0];
                di_q   <= di;
            end else if (state == ACCESS && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (exec) begin
                err   <= misalign;
                rdata <= (misalign || we_q) ? 32'd0 : load_val;
            end
        end
    end

    // Reset forces IDLE asynchronously, so an abandoned store never reaches exec.
    always_ff @(posedge clk) begin
        if (exec && we_q && !misalign) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) mem[a_q[ADDR_W+1:2]][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench: one instance at LATENCY=2 for the data-path cases and one at
// LATENCY=3 for the back-to-back handshake case.
module tb_data_memory_sized;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req2 = 1'b0, req3 = 1'b0;
    logic        we = 1'b0, sign_ext = 1'b0;
    logic [1:0]  size = 2'b10;
    logic [31:0] a = 32'd0, di = 32'd0;
    logic        ready2, done2, err2, ready3, done3, err3;
    logic [31:0] rdata2, rdata3;

    int checks = 0;
    int errors = 0;

    data_memory_sized #(.ADDR_W(5), .LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .req(req2), .we(we), .size(size), .sign_ext(sign_ext),
        .a(a), .di(di), .ready(ready2), .done(done2), .rdata(rdata2), .err(err2));

    data_memory_sized #(.ADDR_W(5), .LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .we(we), .size(size), .sign_ext(sign_ext),
        .a(a), .di(di), .ready(ready3), .done(done3), .rdata(rdata3), .err(err3));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request on the selected instance; called #1 after a clock edge.
    task automatic txn(input int sel, input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] ad, input logic [31:0] d,
                       output logic [31:0] r, output logic e);
        int n;
        we = w; size = sz; sign_ext = sx; a = ad; di = d;
        n = 0;
        while (!(sel == 2 ? ready2 : ready3) && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("ready_wait", 32'(n < 20), 32'd1);
        if (sel == 2) req2 = 1'b1; else req3 = 1'b1;
        @(posedge clk); #1;
        req2 = 1'b0; req3 = 1'b0;
        n = 0;
        while (!(sel == 2 ? done2 : done3) && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("latency", n, (sel == 2) ? 32'd2 : 32'd3);
        r = (sel == 2) ? rdata2 : rdata3;
        e = (sel == 2) ? err2 : err3;
        @(posedge clk); #1;
        chk("done_pulse", 32'(sel == 2 ? done2 : done3), 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic        e;
        int          acc[$];
        int          consec;
        logic        pre, prev_done;

        #1 rst = 1'b1;
        #2;
        chk("rst_ready", 32'(ready2), 32'd1);
        chk("rst_done", 32'(done2), 32'd0);
        chk("rst_rdata", rdata2, 32'd0);
        chk("rst_err", 32'(err2), 32'd0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;

        // word store / load
        txn(2, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, r, e);
        chk("st_word_do", r, 32'd0);
        chk("st_word_err", 32'(e), 32'd0);
        txn(2, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, r, e);
        chk("ld_word_do", r, 32'hDEADBEEF);
        chk("ld_word_err", 32'(e), 32'd0);

        // sub-word
        txn(2, 1'b1, 2'b00, 1'b0, 32'h11, 32'h12345680, r, e);
        chk("st_byte_err", 32'(e), 32'd0);
        txn(2, 1'b0, 2'b00, 1'b1, 32'h11, 32'd0, r, e);
        chk("ld_byte_sx", r, 32'hFFFFFF80);
        txn(2, 1'b0, 2'b01, 1'b0, 32'h10, 32'd0, r, e);
        chk("ld_half_zx", r, 32'h000080EF);
        txn(2, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, r, e);
        chk("ld_word_merged", r, 32'hDEAD80EF);
        txn(2, 1'b0, 2'b01, 1'b1, 32'h12, 32'd0, r, e);
        chk("ld_half_hi_sx", r, 32'hFFFFDEAD);
        txn(2, 1'b0, 2'b00, 1'b0, 32'h13, 32'd0, r, e);
        chk("ld_byte3_zx", r, 32'h000000DE);
        repeat (3) @(posedge clk);
        #1 chk("hold_rdata", rdata2, 32'h000000DE);

        // misalignment / illegal size
        txn(2, 1'b1, 2'b10, 1'b0, 32'h12, 32'h55555555, r, e);
        chk("mis_word_err", 32'(e), 32'd1);
        chk("mis_word_do", r, 32'd0);
        txn(2, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, r, e);
        chk("mis_no_write", r, 32'hDEAD80EF);
        txn(2, 1'b0, 2'b11, 1'b0, 32'h10, 32'd0, r, e);
        chk("size11_err", 32'(e), 32'd1);
        chk("size11_do", r, 32'd0);
        txn(2, 1'b1, 2'b01, 1'b0, 32'h11, 32'hFFFF, r, e);
        chk("mis_half_err", 32'(e), 32'd1);
        txn(2, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, r, e);
        chk("mis_half_no_write", r, 32'hDEAD80EF);

        // address wrap
        txn(2, 1'b1, 2'b10, 1'b0, 32'h80, 32'h12345678, r, e);
        txn(2, 1'b0, 2'b10, 1'b0, 32'h00, 32'd0, r, e);
        chk("wrap", r, 32'h12345678);

        // reset in ACCESS during a store
        txn(2, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, r, e);
        txn(2, 1'b0, 2'b10, 1'b0, 32'h20, 32'd0, r, e);
        chk("pre_rst_val", r, 32'hCAFEF00D);
        we = 1'b1; size = 2'b10; a = 32'h20; di = 32'hFFFFFFFF;
        req2 = 1'b1;
        @(posedge clk); #1 req2 = 1'b0;
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("midrst_ready", 32'(ready2), 32'd1);
        chk("midrst_done", 32'(done2), 32'd0);
        chk("midrst_rdata", rdata2, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        txn(2, 1'b0, 2'b10, 1'b0, 32'h20, 32'd0, r, e);
        chk("abandoned_store", r, 32'hCAFEF00D);

        // req held high on the LATENCY=3 instance
        we = 1'b1; size = 2'b10; sign_ext = 1'b0; a = 32'h04; di = 32'h11111111;
        req3 = 1'b1;
        consec = 0;
        prev_done = 1'b0;
        for (int ed = 1; ed <= 16; ed++) begin
            pre = ready3;
            @(posedge clk); #1;
            if (pre) begin
                acc.push_back(ed);
                if (acc.size() == 1) begin
                    we = 1'b0; a = 32'h08; di = 32'h22222222;
                end
            end
            if (done3 && prev_done) consec++;
            prev_done = done3;
        end
        req3 = 1'b0;
        chk("acc_count", acc.size(), 32'd4);
        if (acc.size() >= 3) begin
            chk("acc_gap1", acc[1] - acc[0], 32'd5);
            chk("acc_gap2", acc[2] - acc[1], 32'd5);
        end
        chk("done_consec", consec, 32'd0);
        txn(3, 1'b0, 2'b10, 1'b0, 32'h04, 32'd0, r, e);
        chk("held_store", r, 32'h11111111);
        txn(3, 1'b0, 2'b10, 1'b0, 32'h08, 32'd0, r, e);
        chk("held_no_stray_write", r, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_memory_sized.md
DATA_MEMORY_SIZED -- requirements
Module: data_memory_sized

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 5, meaning word-index width; depth = 2**ADDR_W 32-bit words.
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to response; legal range 1..15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port req, input, 1 bit: request strobe, sampled only while ready=1.
REQ-006 The block SHALL have port we, input, 1 bit: 1 = store, 0 = load; captured with req.
REQ-007 The block SHALL have port size, input, 2 bits: access size, 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 The block SHALL have port sign_ext, input, 1 bit: for loads, 1 = sign-extend and 0 = zero-extend sub-word data.
REQ-009 The block SHALL have port a, input, 32 bits: byte address.
REQ-010 The block SHALL have port di, input, 32 bits: store data, right-aligned.
REQ-011 The block SHALL have port ready, output, 1 bit: high only in IDLE; combinational decode of state.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle response pulse.
REQ-013 The block SHALL have port do, output, 32 bits: registered load result.
REQ-014 The block SHALL have port err, output, 1 bit: registered, valid with done; misaligned or illegal access.

Function
REQ-015 States SHALL be IDLE, ACCESS, RESP: IDLE->ACCESS on req; ACCESS->RESP when counter==0, else counter decrements; RESP->IDLE unconditionally.
REQ-016 On acceptance the block SHALL latch a, di, we, size and sign_ext, and load a 4-bit counter with LATENCY-1; input changes after acceptance have no effect.
REQ-017 With acceptance at edge 0, the access SHALL execute at edge LATENCY, with done=1 for exactly the following cycle; the minimum request interval is LATENCY+2 cycles.
REQ-018 req while ready=0 SHALL be ignored, with no queueing.
REQ-019 Word index SHALL be a[ADDR_W+1:2], and address bits above it SHALL be ignored, wrapping modulo depth.
REQ-020 Byte lanes SHALL be little-endian, with lane n = bits 8n+7:8n: a byte access uses lane a[1:0], and a half access uses lanes {a[1],0} and {a[1],1}.
REQ-021 Alignment error SHALL be flagged when size=01 and a[0]=1, when size=10 and a[1:0]!=00, or when size=11.
REQ-022 On error the block SHALL leave memory unchanged, with do=0 and err=1 at done.
REQ-023 A store SHALL write only the addressed lanes: byte writes di[7:0], half writes di[15:0], word writes di; other lanes keep their values.
REQ-024 A store response SHALL give do=0 and err=0.
REQ-025 A load SHALL return the addressed lanes right-aligned, extended to 32 bits per sign_ext; sign_ext is ignored for word loads.
REQ-026 do and err SHALL hold their values between done pulses.
REQ-027 Memory SHALL initialise to all-zero at time zero.

Reset
REQ-028 When rst is asserted, the block SHALL immediately go to state IDLE, with counter=0, done=0, err=0 and do=0.
REQ-029 Memory contents SHALL NOT be altered by reset.
REQ-030 Reset mid-operation SHALL abandon the pending access, and an abandoned store SHALL NOT write; the first acceptance is possible at the first clk edge after rst deasserts.

Verification
REQ-031 Bench SHALL cover word store/load: LATENCY=2; store word 0xDEADBEEF at 0x10, then load word at 0x10 -> done 2 cycles after each acceptance; load gives do=0xDEADBEEF, err=0.
REQ-032 Bench SHALL cover sub-word: after REQ-031, store byte 0x80 at 0x11, then load byte at 0x11 with sign_ext=1 -> do=0xFFFFFF80; load half at 0x10 with sign_ext=0 -> do=0x000080EF; load word at 0x10 -> do=0xDEAD80EF.
REQ-033 Bench SHALL cover misalignment: store word at 0x12 -> err=1, do=0; a following load word at 0x10 still returns 0xDEAD80EF; size=11 at any address -> err=1.
REQ-034 Bench SHALL cover handshake: hold req high continuously with LATENCY=3 -> acceptances 5 cycles apart; done never high on 2 consecutive cycles; changing a/di after acceptance alters nothing.
REQ-035 Bench SHALL cover wrap: ADDR_W=5; store word 0x12345678 at 0x80, then load word at 0x00 -> do=0x12345678.
REQ-036 Bench SHALL cover reset mid-operation: assert rst while in ACCESS during a store of 0xFFFFFFFF to 0x20 -> ready=1, done=0 immediately; a later load of 0x20 returns its prior value.
